// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the instruction-fetch port and the
// load/store data port. Alternating priority on contention, registered
// outputs, and an optional wait-state timeout that aborts the access with
// an error response.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  // fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  // data port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  // memory side
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_be,
  input  logic        m_ready,
  input  logic [31:0] m_rdata
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_favor_d;   // 1: data port wins the next tie
  logic [CW-1:0] r_cnt;       // wait states seen in the current access

  logic w_busy;
  logic w_abort;
  logic w_done;
  logic w_arb;
  logic w_pick_d;
  logic w_pick_if;

  // Arbitration decision and next state; an abort edge arbitrates like a completion edge.
  always_comb begin
    w_busy      = (r_state != IDLE);
    w_abort     = (TIMEOUT != 0) && w_busy && !m_ready && (r_cnt == LIMIT);
    w_done      = w_busy && (m_ready || w_abort);
    w_arb       = !w_busy || w_done;
    w_pick_d    = d_req && (!if_req || r_favor_d);
    w_pick_if   = if_req && !w_pick_d;
    w_state_nxt = r_state;
    if (w_arb) begin
      if (w_pick_d)       w_state_nxt = BUSY_D;
      else if (w_pick_if) w_state_nxt = BUSY_IF;
      else                w_state_nxt = IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Registered grant, memory-side request fields, favor and timeout counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      m_req     <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      m_be      <= '0;
      r_favor_d <= 1'b1;
      r_cnt     <= '0;
    end else begin
      if_gnt <= w_arb && w_pick_if;
      d_gnt  <= w_arb && w_pick_d;
      if (w_arb) begin
        m_req <= w_pick_if || w_pick_d;
        r_cnt <= '0;
        if (w_pick_d) begin
          m_we      <= d_we;
          m_addr    <= d_addr;
          m_wdata   <= d_wdata;
          m_be      <= d_be;
          r_favor_d <= 1'b0;
        end else if (w_pick_if) begin
          m_we      <= 1'b0;
          m_addr    <= if_addr;
          m_wdata   <= '0;
          m_be      <= '1;
          r_favor_d <= 1'b1;
        end
      end else if (!m_ready) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Registered one-cycle responses; m_we still names the finishing access here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_rvalid <= 1'b0;
      if_err    <= 1'b0;
      if_rdata  <= '0;
      d_rvalid  <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= '0;
    end else begin
      if_rvalid <= w_done && (r_state == BUSY_IF);
      d_rvalid  <= w_done && (r_state == BUSY_D);
      if_err    <= w_done && (r_state == BUSY_IF) && w_abort;
      d_err     <= w_done && (r_state == BUSY_D) && w_abort;
      if (w_done && (r_state == BUSY_IF))
        if_rdata <= w_abort ? '0 : m_rdata;
      if (w_done && (r_state == BUSY_D))
        d_rdata <= (w_abort || m_we) ? '0 : m_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed reset / idle / single
// fetch / mid-access reset cases, then randomized two-port traffic against a
// memory model whose wait states depend on the address. Expected responses
// are queued per port when a request is issued and checked by a monitor.
module tb_mem_port_arbiter;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        m_req, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  logic        m_ready = 1'b0;
  logic [31:0] m_rdata = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_ready(m_ready), .m_rdata(m_rdata)
  );

  logic [139:0] w_all;
  assign w_all = {if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_err, d_rdata,
                  m_req, m_we, m_addr, m_wdata, m_be};

  int checks = 0;
  int errors = 0;

  typedef struct packed {logic err; logic [31:0] rdata;} resp_t;
  resp_t q_if[$];
  resp_t q_d[$];
  resp_t e_if, e_d;

  bit          mon_en = 1'b0;
  bit          last_d = 1'b0;   // last granted port was the data port
  logic        p_if_req = 1'b0, p_d_req = 1'b0, p_d_we = 1'b0;
  logic [31:0] p_if_addr = '0, p_d_addr = '0, p_d_wdata = '0;
  logic [3:0]  p_d_be = '0;
  bit          c_valid = 1'b0;
  logic        c_we = 1'b0;
  logic [31:0] c_addr = '0, c_wdata = '0;
  logic [3:0]  c_be = '0;

  // memory model state
  int  wcnt = 0;
  bit  pm_req = 1'b0, pm_ready = 1'b0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Memory latency in wait states, keyed by address; 0xF in bits 7:4 never answers.
  function automatic int wait_of(input logic [31:0] a);
    return (a[7:4] == 4'hF) ? 99 : int'(a[6:4]);
  endfunction

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  function automatic resp_t expect_of(input logic [31:0] a, input logic store);
    resp_t r;
    r.err   = (wait_of(a) >= int'(TO));
    r.rdata = (r.err || store) ? 32'h0 : rd_of(a);
    return r;
  endfunction

  // Monitor: responses against the scoreboard, grants against alternating priority.
  always @(negedge clk) begin
    if (mon_en) begin
      if (if_rvalid) begin
        if (q_if.size() == 0) chk("if_rvalid_unexpected", 1, 0);
        else begin
          e_if = q_if.pop_front();
          chk("if_resp", {if_err, if_rdata}, {e_if.err, e_if.rdata});
        end
      end
      if (d_rvalid) begin
        if (q_d.size() == 0) chk("d_rvalid_unexpected", 1, 0);
        else begin
          e_d = q_d.pop_front();
          chk("d_resp", {d_err, d_rdata}, {e_d.err, e_d.rdata});
        end
      end
      if (if_gnt) begin
        chk("if_gnt_req", {d_gnt, p_if_req}, {1'b0, 1'b1});
        if (p_d_req) chk("if_gnt_favor", last_d, 1);
        chk("if_gnt_mfields", {m_req, m_we, m_addr, m_wdata, m_be},
            {1'b1, 1'b0, p_if_addr, 32'h0, 4'hF});
        last_d  = 1'b0;
        c_valid = 1'b1; c_we = 1'b0; c_addr = p_if_addr; c_wdata = '0; c_be = 4'hF;
      end else if (d_gnt) begin
        chk("d_gnt_req", p_d_req, 1);
        if (p_if_req) chk("d_gnt_favor", last_d, 0);
        chk("d_gnt_mfields", {m_req, m_we, m_addr, m_wdata, m_be},
            {1'b1, p_d_we, p_d_addr, p_d_wdata, p_d_be});
        last_d  = 1'b1;
        c_valid = 1'b1; c_we = p_d_we; c_addr = p_d_addr; c_wdata = p_d_wdata; c_be = p_d_be;
      end else if (m_req && c_valid) begin
        chk("m_stable", {m_we, m_addr, m_wdata, m_be}, {c_we, c_addr, c_wdata, c_be});
      end
    end
    if (!reset) begin
      last_d  = 1'b0;
      c_valid = 1'b0;
    end
    p_if_req = if_req; p_if_addr = if_addr;
    p_d_req = d_req; p_d_we = d_we; p_d_addr = d_addr; p_d_wdata = d_wdata; p_d_be = d_be;
  end

  // Random two-port traffic; inputs change 1 time unit after the rising edge.
  task automatic run_random(input int cycles, input int pct);
    bool_loop: for (int n = 0; n < cycles + 400; n++) begin
      @(posedge clk);
      #1;
      if (pm_req) begin
        if (pm_ready) wcnt = 0;
        else begin
          wcnt++;
          if (wcnt == int'(TO)) wcnt = 0;
        end
      end
      if (if_req && if_gnt) if_req = 1'b0;
      if (d_req && d_gnt)   d_req  = 1'b0;
      if (n < cycles) begin
        if (!if_req && $urandom_range(99) < pct) begin
          if_addr = $urandom;
          if_req  = 1'b1;
          q_if.push_back(expect_of(if_addr, 1'b0));
        end
        if (!d_req && $urandom_range(99) < pct) begin
          d_we    = 1'($urandom_range(1));
          d_addr  = $urandom;
          d_wdata = $urandom;
          d_be    = 4'($urandom_range(15));
          d_req   = 1'b1;
          q_d.push_back(expect_of(d_addr, d_we));
        end
      end else if (!if_req && !d_req && q_if.size() == 0 && q_d.size() == 0) begin
        break;
      end
      if (m_req) begin
        m_ready = (wcnt == wait_of(m_addr));
        m_rdata = rd_of(m_addr);
      end else begin
        m_ready = 1'($urandom_range(1));
        m_rdata = $urandom;
      end
      pm_req   = m_req;
      pm_ready = m_ready;
    end
    chk("drain", {q_if.size() == 0, q_d.size() == 0, !if_req, !d_req}, 4'hF);
    if_req = 1'b0;
    d_req  = 1'b0;
  endtask

  initial begin
    bit got;
    // reset state
    repeat (2) @(negedge clk);
    chk("reset_outputs", w_all, '0);
    reset = 1'b1;

    // m_ready while idle with no request is ignored
    @(negedge clk);
    m_ready = 1'b1;
    m_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    m_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_mready", {m_req, if_rvalid, d_rvalid, if_gnt, d_gnt}, '0);
    end

    // single zero-wait fetch
    if_req  = 1'b1;
    if_addr = 32'h100;
    m_ready = 1'b1;
    m_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("fetch_gnt", {if_gnt, d_gnt, m_req, m_we, m_addr, m_be, if_rvalid},
        {1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 4'hF, 1'b0});
    if_req = 1'b0;
    @(negedge clk);
    chk("fetch_resp", {if_rvalid, if_err, if_rdata, if_gnt}, {1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0});
    m_ready = 1'b0;
    @(negedge clk);
    chk("fetch_idle", {m_req, if_rvalid}, 2'b00);

    // reset during an access drops it
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h300;
    d_be   = 4'hF;
    got    = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = d_gnt;
    end
    chk("rst_access_gnt", got, 1);
    d_req = 1'b0;
    @(negedge clk);
    chk("rst_access_busy", m_req, 1);
    #2 reset = 1'b0;
    #1 chk("rst_async_outputs", w_all, '0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_rvalid", {m_req, d_rvalid, if_rvalid}, 3'b000);
    end

    // randomized traffic, light then heavy contention
    wcnt = 0; pm_req = 1'b0; pm_ready = 1'b0;
    mon_en = 1'b1;
    run_random(800, 30);
    run_random(800, 95);
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: actual=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
